// File: rtl/pulse_burst_generator.sv
// Pulse burst generator: count-programmable bursts of high/low phases with registered outputs.
// Optional feature: define PULSE_BURST_REPEAT_EN to add cfg_repeat (back-to-back burst repetition).
module pulse_burst_generator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_high_len,
  input  logic [CNT_W-1:0] cfg_low_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_idle_level,
`ifdef PULSE_BURST_REPEAT_EN
  input  logic             cfg_repeat,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] high_len_q;
  logic [CNT_W-1:0] low_len_q;
  logic [CNT_W-1:0] count_q;
  logic             idle_q;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] pulse_cnt;
  logic             repeat_req;

`ifdef PULSE_BURST_REPEAT_EN
  assign repeat_req = cfg_repeat;
`else
  assign repeat_req = 1'b0;
`endif

  // Phase counter counts down to zero; a zero length behaves like length one.
  function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      high_len_q <= '0;
      low_len_q  <= '0;
      count_q    <= '0;
      idle_q     <= 1'b0;
      phase_cnt  <= '0;
      pulse_cnt  <= '0;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        phase_cnt <= '0;
        pulse_cnt <= '0;
        pulse_out <= idle_q;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            pulse_out <= cfg_idle_level;
            if (trigger) begin
              if (cfg_count == '0) begin
                done <= 1'b1;
              end else begin
                high_len_q <= cfg_high_len;
                low_len_q  <= cfg_low_len;
                count_q    <= cfg_count;
                idle_q     <= cfg_idle_level;
                phase_cnt  <= last_idx(cfg_high_len);
                pulse_cnt  <= cfg_count;
                pulse_out  <= ~cfg_idle_level;
                busy       <= 1'b1;
                state      <= ST_HIGH;
              end
            end
          end
          ST_HIGH: begin
            if (phase_cnt == '0) begin
              phase_cnt <= last_idx(low_len_q);
              pulse_out <= idle_q;
              state     <= ST_LOW;
            end else begin
              phase_cnt <= phase_cnt - ONE;
            end
          end
          ST_LOW: begin
            if (phase_cnt != '0) begin
              phase_cnt <= phase_cnt - ONE;
            end else if (pulse_cnt != ONE) begin
              // pulse_cnt holds pulses remaining including the current one
              pulse_cnt <= pulse_cnt - ONE;
              phase_cnt <= last_idx(high_len_q);
              pulse_out <= ~idle_q;
              state     <= ST_HIGH;
            end else if (repeat_req) begin
              done      <= 1'b1;
              pulse_cnt <= count_q;
              phase_cnt <= last_idx(high_len_q);
              pulse_out <= ~idle_q;
              state     <= ST_HIGH;
            end else begin
              done      <= 1'b1;
              pulse_cnt <= '0;
              pulse_out <= idle_q;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_generator.sv
// Self-checking bench for pulse_burst_generator: expected {pulse_out,busy,done} per cycle
// are queued when a burst is launched and compared one per cycle after each rising edge.
module tb_pulse_burst_generator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trigger;
  logic             abort;
  logic [CNT_W-1:0] cfg_high_len;
  logic [CNT_W-1:0] cfg_low_len;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_idle_level;
  logic             cfg_repeat;
  logic             pulse_out;
  logic             busy;
  logic             done;

  logic [2:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  string      cur_tag = "none";

  always #5 clk = ~clk;

  pulse_burst_generator #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trigger        (trigger),
    .abort          (abort),
    .cfg_high_len   (cfg_high_len),
    .cfg_low_len    (cfg_low_len),
    .cfg_count      (cfg_count),
    .cfg_idle_level (cfg_idle_level),
`ifdef PULSE_BURST_REPEAT_EN
    .cfg_repeat     (cfg_repeat),
`endif
    .pulse_out      (pulse_out),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock; sample outputs 1 time unit after the edge and score against the queue.
  task automatic tick();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(cur_tag, {pulse_out, busy, done}, e);
    end
  endtask

  task automatic push_burst(input int h, input int l, input int c, input logic idle);
    int he, le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    for (int p = 0; p < c; p++) begin
      for (int i = 0; i < he; i++) exp_q.push_back({~idle, 1'b1, 1'b0});
      for (int i = 0; i < le; i++) exp_q.push_back({idle, 1'b1, 1'b0});
    end
    exp_q.push_back({idle, 1'b0, 1'b1});
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic set_cfg(input int h, input int l, input int c, input logic idle);
    cfg_high_len   = CNT_W'(h);
    cfg_low_len    = CNT_W'(l);
    cfg_count      = CNT_W'(c);
    cfg_idle_level = idle;
  endtask

  task automatic run_burst(input string tag, input int h, input int l, input int c, input logic idle);
    cur_tag = tag;
    set_cfg(h, l, c, idle);
    tick();
    trigger = 1'b1;
    push_burst(h, l, c, idle);
    tick();
    trigger = 1'b0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    trigger = 1'b0;
    abort = 1'b0;
    cfg_repeat = 1'b0;
    set_cfg(5, 5, 5, 1'b1);
    tick();
    tick();
    check("reset_pulse", pulse_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Idle level follows the configuration with one cycle of latency.
    rst_n = 1'b1;
    tick();
    check("idle_follow_hi", pulse_out, 1);
    cfg_idle_level = 1'b0;
    check("idle_latency", pulse_out, 1);
    tick();
    check("idle_follow_lo", pulse_out, 0);

    // First trigger after reset; 2 high, 3 low, 3 pulses.
    cur_tag = "basic";
    set_cfg(2, 3, 3, 1'b0);
    trigger = 1'b1;
    push_burst(2, 3, 3, 1'b0);
    tick();
    trigger = 1'b0;
    drain();

    run_burst("zero_len", 0, 0, 4, 1'b0);
    run_burst("idle_hi", 3, 1, 2, 1'b1);
    run_burst("rand_burst", $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 5), 1'($urandom_range(0, 1)));

    // count = 0: done for one cycle, no activity.
    cur_tag = "count_zero";
    set_cfg(2, 2, 0, 1'b1);
    tick();
    trigger = 1'b1;
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b100);
    tick();
    trigger = 1'b0;
    drain();

    // Abort in the first HIGH cycle of pulse 2, with a simultaneous trigger.
    cur_tag = "abort";
    set_cfg(3, 2, 3, 1'b1);
    tick();
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(3'b010);
    for (int i = 0; i < 2; i++) exp_q.push_back(3'b110);
    exp_q.push_back(3'b010);
    for (int i = 0; i < 4; i++) exp_q.push_back(3'b100);
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    trigger = 1'b1;
    tick();
    abort = 1'b0;
    trigger = 1'b0;
    drain();

    // Retrigger and config changes while busy have no effect.
    cur_tag = "retrigger";
    set_cfg(1, 1, 2, 1'b0);
    tick();
    trigger = 1'b1;
    push_burst(1, 1, 2, 1'b0);
    exp_q.push_back(3'b000);
    tick();
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    cfg_count = 8'd5;
    cfg_high_len = 8'd4;
    tick();
    trigger = 1'b0;
    drain();

    // Reset in LOW phase of pulse 1: outputs all zero, no done afterwards.
    cur_tag = "reset_mid";
    set_cfg(2, 4, 2, 1'b1);
    tick();
    trigger = 1'b1;
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    tick();
    trigger = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drain();

    run_burst("max_count", 1, 1, 255, 1'b0);

`ifdef PULSE_BURST_REPEAT_EN
    // Repeat: three back-to-back bursts of 2 pulses, repeat dropped during the third.
    cur_tag = "repeat";
    set_cfg(1, 1, 2, 1'b0);
    cfg_repeat = 1'b1;
    tick();
    trigger = 1'b1;
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back((b == 0) ? 3'b110 : 3'b111);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b110);
      exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    cfg_repeat = 1'b0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_burst_generator.md
PULSE_BURST_GENERATOR -- requirements
Module: pulse_burst_generator

Interface
REQ-001 Parameter: CNT_W, default 8, width of the phase-length and pulse-count configuration fields.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 trigger  input  1  single-cycle start strobe, driven by the upstream rising-edge detector.
REQ-005 abort  input  1  synchronous stop request, level-sampled every cycle.
REQ-006 cfg_high_len  input  CNT_W  active-phase length in cycles; 0 treated as 1.
REQ-007 cfg_low_len  input  CNT_W  inactive-phase length in cycles; 0 treated as 1.
REQ-008 cfg_count  input  CNT_W  pulses per burst.
REQ-009 cfg_idle_level  input  1  output level outside active phases; active level is its inverse.
REQ-010 pulse_out  output  1  registered burst waveform.
REQ-011 busy  output  1  registered; high while in HIGH or LOW state.
REQ-012 done  output  1  registered; one-cycle strobe on normal burst completion.

Function
REQ-013 The FSM SHALL have states IDLE, HIGH and LOW, held in a registered state vector.
REQ-014 In IDLE with trigger=1, abort=0 and cfg_count!=0, the block SHALL latch all cfg_* inputs and enter HIGH on the next cycle.
REQ-015 In IDLE with trigger=1 and cfg_count=0, the block SHALL stay in IDLE and assert done for exactly the next cycle.
REQ-016 All outputs SHALL be registered: after a trigger in cycle T, the first active pulse_out level and busy=1 SHALL appear in cycle T+1.
REQ-017 HIGH SHALL last exactly max(high_len,1) cycles with pulse_out = ~idle_level, then go to LOW.
REQ-018 LOW SHALL last exactly max(low_len,1) cycles with pulse_out = idle_level.
REQ-019 At the end of LOW, the block SHALL return to HIGH if pulses remain; otherwise it SHALL enter IDLE.
REQ-020 On entering IDLE after normal completion, the block SHALL assert done for exactly one cycle, in the first IDLE cycle.
REQ-021 Phase and pulse counters SHALL be CNT_W wide and SHALL never wrap; cfg_count = 2^CNT_W-1 SHALL produce exactly that many pulses.
REQ-022 A trigger received while busy=1 SHALL be ignored, and cfg_* changes while busy SHALL have no effect on the running burst.
REQ-023 abort=1 in any state SHALL force IDLE on the next cycle with pulse_out = latched idle_level, busy=0 and done=0.
REQ-024 abort SHALL take priority over trigger in the same cycle, so no burst starts.
REQ-025 In IDLE, pulse_out SHALL follow registered cfg_idle_level with one cycle of latency.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL force state=IDLE, all counters=0, latched cfg=0, pulse_out=0, busy=0 and done=0.
REQ-027 Reset asserted mid-burst SHALL terminate the burst immediately, with no done strobe.
REQ-028 The first trigger after reset release SHALL be honoured.

Configuration
REQ-029 Macro PULSE_BURST_REPEAT_EN, when defined, SHALL add input port cfg_repeat (1 bit).
REQ-030 With PULSE_BURST_REPEAT_EN defined, at the end of the last LOW phase the block SHALL sample cfg_repeat.
REQ-031 With PULSE_BURST_REPEAT_EN defined and cfg_repeat=1 at that sample, the block SHALL pulse done for one cycle, reload the pulse counter and enter HIGH in the next cycle without an IDLE cycle, keeping busy=1.
REQ-032 With PULSE_BURST_REPEAT_EN defined, repeating SHALL continue until abort, reset or cfg_repeat=0 at a burst end.
REQ-033 Without PULSE_BURST_REPEAT_EN, the cfg_repeat port SHALL be absent and every burst SHALL be single-shot.

Verification
REQ-034 Basic burst: high_len=2, low_len=3, count=3, idle_level=0, trigger at T -> pulse_out high T+1..T+2, T+6..T+7, T+11..T+12; busy high T+1..T+15; done=1 only at T+16.
REQ-035 Zero lengths: high_len=0, low_len=0, count=4 -> 1-cycle-high/1-cycle-low square wave of 4 pulses; busy high for 8 cycles.
REQ-036 count=0 trigger -> busy stays 0, pulse_out unchanged, done=1 for one cycle at T+1.
REQ-037 Abort mid-HIGH of pulse 2 with idle_level=1 -> next cycle pulse_out=1, busy=0; done never asserts; a trigger in the same cycle as the abort is ignored.
REQ-038 Retrigger and reset: second trigger during busy produces no extra pulses; rst_n=0 mid-LOW -> all outputs 0 on next edge.
REQ-039 With PULSE_BURST_REPEAT_EN, cfg_repeat=1, count=2 -> continuous pulses, done every 2 pulses; drop cfg_repeat -> exactly one more burst completes, then IDLE.
